// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch buffer.
package fetch_pkg;

   // Canonical RISC-V NOP (addi x0, x0, 0), used to stand in for a misaligned fetch.
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // One queue entry: the fetch PC, the returned instruction and its state.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
      logic        filled;
      logic        misaligned;
   } fetch_slot_t;

endpackage

// File: rtl/fetch_slot_queue.sv
// fetch_slot_queue: in-order slot storage for fetched instructions.
// Slots are reserved at the tail, filled oldest-unfilled-first, popped at the head.
module fetch_slot_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     reserve,
   input  logic [31:0]              reservePc,
   input  logic                     reserveFilled,
   input  logic [31:0]              reserveData,
   input  logic                     reserveMisaligned,
   input  logic                     fill,
   input  logic [31:0]              fillData,
   input  logic                     pop,
   output logic                     headValid,
   output logic [31:0]              headPc,
   output logic [31:0]              headData,
   output logic                     headMisaligned,
   output logic [$clog2(DEPTH):0]   reserved,
   output logic [$clog2(DEPTH):0]   unfilled
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE = 1;

   fetch_slot_t   slots [DEPTH];
   logic [PW-1:0] headPtr;
   logic [PW-1:0] tailPtr;
   logic [PW-1:0] fillPtr;
   logic [PW-1:0] scanIdx;
   logic          fillFound;
   logic          popEn;

   assign headValid      = (reserved != '0) && slots[headPtr].filled;
   assign headPc         = slots[headPtr].pc;
   assign headData       = slots[headPtr].data;
   assign headMisaligned = slots[headPtr].misaligned;
   assign popEn          = pop && headValid;

   // Walk occupied slots from the head: locate the oldest unfilled one and count unfilled.
   // Misaligned slots are filled at reservation, so unfilled slots need not be contiguous.
   always_comb begin
      fillFound = 1'b0;
      fillPtr   = headPtr;
      scanIdx   = headPtr;
      unfilled  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scanIdx = headPtr + PW'(i);
         if ((CW'(i) < reserved) && !slots[scanIdx].filled) begin
            unfilled = unfilled + CW'(1);
            if (!fillFound) begin
               fillFound = 1'b1;
               fillPtr   = scanIdx;
            end
         end
      end
   end

   // Slot state and pointers: reserve at tail, fill oldest unfilled, pop at head.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         headPtr  <= '0;
         tailPtr  <= '0;
         reserved <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            slots[i].filled <= 1'b0;
         end
      end else begin
         if (reserve) begin
            slots[tailPtr] <= '{pc: reservePc, data: reserveData,
                               filled: reserveFilled, misaligned: reserveMisaligned};
            tailPtr <= tailPtr + PTR_ONE;
         end
         if (fill && fillFound) begin
            slots[fillPtr].data   <= fillData;
            slots[fillPtr].filled <= 1'b1;
         end
         if (popEn) begin
            headPtr <= headPtr + PTR_ONE;
         end
         reserved <= reserved + CW'(reserve) - CW'(popEn);
      end
   end

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: fetch stage between ProgramCounter and decode. Issues requests to a
// req/gnt/rvalid instruction memory, queues DEPTH instructions tagged with their PC,
// and discards queued and in-flight instructions on a redirect flush.
// Optional build macro FETCH_MISALIGN_CHECK_EN: a misaligned pc yields a local NOP
// slot flagged misaligned instead of a memory request.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic        pcAdvance,
   input  logic        flush,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemGnt,
   input  logic        imemRvalid,
   input  logic [31:0] imemRdata,
   output logic        instValid,
   output logic [31:0] instData,
   output logic [31:0] instPc,
   input  logic        instReady,
   output logic        instMisaligned
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] SUM_MAX = {1'b0, {CW{1'b1}}};

   logic [CW-1:0] reserved;
   logic [CW-1:0] unfilled;
   logic [CW-1:0] dropCnt;
   logic [CW-1:0] flushDrop;
   logic [CW:0]   dropSum;
   logic          misalignedPc;
   logic          slotFree;
   logic          grant;
   logic          misReserve;
   logic          fillEn;
   logic          headValid;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic          headMisaligned;
   assign misalignedPc   = (pc[1:0] != 2'b00);
   assign instMisaligned = headValid && headMisaligned;
`else
   assign misalignedPc   = 1'b0;
   assign instMisaligned = 1'b0;
`endif

   // A slot is always kept for every outstanding request, so memory is never stalled.
   assign slotFree   = (reserved < CW'(DEPTH));
   assign imemReq    = !reset && !flush && slotFree && !misalignedPc;
   assign misReserve = !reset && !flush && slotFree && misalignedPc;
   assign imemAddr   = {pc[31:2], 2'b00};
   assign grant      = imemReq && imemGnt;
   assign pcAdvance  = grant || misReserve;
   assign fillEn     = imemRvalid && (dropCnt == '0) && !flush;
   assign instValid  = headValid;

   // Responses owed after a flush: pending drops plus unfilled slots, minus one answered now.
   // Back-to-back flushes could exceed the counter, so the total saturates.
   always_comb begin
      dropSum = {1'b0, dropCnt} + {1'b0, unfilled};
      if (imemRvalid && (dropSum != '0)) begin
         dropSum = dropSum - 1'b1;
      end
      if (dropSum > SUM_MAX) begin
         flushDrop = SUM_MAX[CW-1:0];
      end else begin
         flushDrop = dropSum[CW-1:0];
      end
   end

   // Count of in-flight responses that belong to flushed fetches and must be discarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         dropCnt <= '0;
      end else if (flush) begin
         dropCnt <= flushDrop;
      end else if (imemRvalid && (dropCnt != '0)) begin
         dropCnt <= dropCnt - CW'(1);
      end
   end

   fetch_slot_queue #(.DEPTH(DEPTH)) slotQueue (
      .clk               (clk),
      .reset             (reset),
      .clear             (flush),
      .reserve           (grant || misReserve),
      .reservePc         (pc),
      .reserveFilled     (misReserve),
      .reserveData       (NOP_INST),
      .reserveMisaligned (misReserve),
      .fill              (fillEn),
      .fillData          (imemRdata),
      .pop               (instReady && !flush),
      .headValid         (headValid),
      .headPc            (instPc),
      .headData          (instData),
`ifdef FETCH_MISALIGN_CHECK_EN
      .headMisaligned    (headMisaligned),
`else
      .headMisaligned    (),
`endif
      .reserved          (reserved),
      .unfilled          (unfilled)
   );

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed bench for fetch_buffer with an in-order memory responder,
// a PC model and a scoreboard of expected {pc, data} pairs checked at each pop.
module tb_fetch_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        pcAdvance;
   logic        flush;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemGnt;
   logic        imemRvalid;
   logic [31:0] imemRdata;
   logic        instValid;
   logic [31:0] instData;
   logic [31:0] instPc;
   logic        instReady;
   logic        instMisaligned;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] pendQ[$];
   int          errors = 0;
   int          checks = 0;
   int          grantCnt = 0;
   int          popCnt = 0;
   logic        autoResp = 1'b1;
   logic        pcAuto = 1'b0;
   logic        injectRsp = 1'b0;
   logic        advNext = 1'b0;
   logic        seen;

   fetch_buffer #(.DEPTH(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .pc             (pc),
      .pcAdvance      (pcAdvance),
      .flush          (flush),
      .imemReq        (imemReq),
      .imemAddr       (imemAddr),
      .imemGnt        (imemGnt),
      .imemRvalid     (imemRvalid),
      .imemRdata      (imemRdata),
      .instValid      (instValid),
      .instData       (instData),
      .instPc         (instPc),
      .instReady      (instReady),
      .instMisaligned (instMisaligned)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memData(input logic [31:0] a);
      return a ^ 32'hA5A5_1234;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset     = 1'b1;
      flush     = 1'b0;
      instReady = 1'b0;
      imemGnt   = 1'b0;
      autoResp  = 1'b1;
      pcAuto    = 1'b0;
      injectRsp = 1'b0;
      pc        = 32'h0;
      repeat (2) nextCycle();
      reset = 1'b0;
   endtask

   // Memory responder and PC model: one in-order response per cycle, PC steps after pcAdvance.
   initial begin
      imemRvalid = 1'b0;
      imemRdata  = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         if (injectRsp) begin
            imemRvalid = 1'b1;
            imemRdata  = 32'hDEAD_BEEF;
            injectRsp  = 1'b0;
         end else if (autoResp && pendQ.size() > 0) begin
            imemRvalid = 1'b1;
            imemRdata  = memData(pendQ.pop_front());
         end else begin
            imemRvalid = 1'b0;
         end
         if (pcAuto && advNext) pc = pc + 32'd4;
      end
   end

   // Mid-cycle monitor: records grants, pushes expectations on pcAdvance, checks pops.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            pendQ.delete();
            expQ.delete();
            grantCnt = 0;
            advNext  = 1'b0;
         end else begin
            advNext = pcAdvance;
            if (imemReq && imemGnt) begin
               pendQ.push_back(imemAddr);
               grantCnt++;
            end
            if (flush) begin
               expQ.delete();
            end else begin
               if (instValid && instReady) begin
                  chk("sb_nonempty", 32'(expQ.size() != 0), 32'd1);
                  if (expQ.size() != 0) begin
                     chk("sb_pc", instPc, expQ[0].pc);
                     chk("sb_data", instData, expQ[0].data);
                     void'(expQ.pop_front());
                  end
                  popCnt++;
                  $display("pop  pc=%08h data=%08h", instPc, instData);
               end
               if (pcAdvance) begin
                  expQ.push_back('{pc: pc,
                                   data: imemReq ? memData(imemAddr) : 32'h0000_0013});
                  $display("fetch pc=%08h req=%0d", pc, imemReq);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, with a grant offered to prove it is not taken.
      doReset();
      reset   = 1'b1;
      imemGnt = 1'b1;
      @(negedge clk);
      chk("rst_imemReq", 32'(imemReq), 32'd0);
      chk("rst_pcAdvance", 32'(pcAdvance), 32'd0);
      chk("rst_instValid", 32'(instValid), 32'd0);
      chk("rst_instMisaligned", 32'(instMisaligned), 32'd0);
      chk("rst_reserved", 32'(dut.reserved), 32'd0);
      chk("rst_dropCnt", 32'(dut.dropCnt), 32'd0);

      // Streaming fetch: first instruction valid two cycles after the first grant.
      doReset();
      imemGnt = 1'b1; instReady = 1'b1; pcAuto = 1'b1;
      @(negedge clk);
      chk("t1_c0_pcAdvance", 32'(pcAdvance), 32'd1);
      chk("t1_c0_imemAddr", imemAddr, 32'h0);
      chk("t1_c0_instValid", 32'(instValid), 32'd0);
      nextCycle(); @(negedge clk);
      chk("t1_c1_instValid", 32'(instValid), 32'd0);
      nextCycle(); @(negedge clk);
      chk("t1_c2_instValid", 32'(instValid), 32'd1);
      chk("t1_c2_instPc", instPc, 32'h0);
      popCnt = 0;
      repeat (6) nextCycle();
      @(negedge clk);
      chk("t1_pops", 32'(popCnt >= 3), 32'd1);

      // Back-pressure: exactly DEPTH grants, then one pop frees one slot.
      doReset();
      imemGnt = 1'b1; pcAuto = 1'b1;
      repeat (8) nextCycle();
      @(negedge clk);
      chk("t2_grants_full", 32'(grantCnt), 32'd4);
      chk("t2_req_full", 32'(imemReq), 32'd0);
      chk("t2_head_pc", instPc, 32'h0);
      nextCycle();
      instReady = 1'b1;
      nextCycle();
      instReady = 1'b0;
      repeat (3) nextCycle();
      @(negedge clk);
      chk("t2_grants_after_pop", 32'(grantCnt), 32'd5);
      chk("t2_req_refull", 32'(imemReq), 32'd0);
      chk("t2_head_pc_after_pop", instPc, 32'h4);

      // Flush with three responses outstanding: they are dropped, 0x100 arrives first.
      doReset();
      autoResp = 1'b0; imemGnt = 1'b1; pcAuto = 1'b1;
      repeat (3) nextCycle();
      imemGnt = 1'b0;
      nextCycle();
      chk("t3_grants", 32'(grantCnt), 32'd3);
      pcAuto = 1'b0; flush = 1'b1; pc = 32'h100;
      @(negedge clk);
      chk("t3_flush_req", 32'(imemReq), 32'd0);
      nextCycle();
      flush = 1'b0;
      @(negedge clk);
      chk("t3_reserved", 32'(dut.reserved), 32'd0);
      chk("t3_dropCnt", 32'(dut.dropCnt), 32'd3);
      chk("t3_instValid", 32'(instValid), 32'd0);
      nextCycle();
      autoResp = 1'b1; imemGnt = 1'b1; instReady = 1'b1; pcAuto = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (instValid) begin
            seen = 1'b1;
            chk("t3_first_pc", instPc, 32'h100);
            chk("t3_first_data", instData, memData(32'h100));
         end
      end
      chk("t3_valid_seen", 32'(seen), 32'd1);
      chk("t3_dropCnt_drained", 32'(dut.dropCnt), 32'd0);

      // Flush coinciding with a response and a valid pop.
      doReset();
      imemGnt = 1'b1; pcAuto = 1'b1;
      nextCycle();
      nextCycle();
      pcAuto = 1'b0; flush = 1'b1; instReady = 1'b1; pc = 32'h200; imemGnt = 1'b0;
      @(negedge clk);
      chk("t4_pre_valid", 32'(instValid), 32'd1);
      chk("t4_pre_rvalid", 32'(imemRvalid), 32'd1);
      nextCycle();
      flush = 1'b0; instReady = 1'b0;
      @(negedge clk);
      chk("t4_instValid", 32'(instValid), 32'd0);
      chk("t4_dropCnt", 32'(dut.dropCnt), 32'd0);
      chk("t4_reserved", 32'(dut.reserved), 32'd0);

      // Misaligned pc.
      doReset();
      pc = 32'h6;
      @(negedge clk);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("t5_req", 32'(imemReq), 32'd0);
      chk("t5_pcAdvance", 32'(pcAdvance), 32'd1);
      nextCycle();
      @(negedge clk);
      chk("t5_valid", 32'(instValid), 32'd1);
      chk("t5_data", instData, 32'h0000_0013);
      chk("t5_pc", instPc, 32'h6);
      chk("t5_misaligned", 32'(instMisaligned), 32'd1);
`else
      chk("t5_addr", imemAddr, 32'h4);
      chk("t5_req", 32'(imemReq), 32'd1);
      chk("t5_pcAdvance_nognt", 32'(pcAdvance), 32'd0);
      nextCycle();
      imemGnt = 1'b1;
      @(negedge clk);
      chk("t5_pcAdvance", 32'(pcAdvance), 32'd1);
      nextCycle();
      imemGnt = 1'b0;
      nextCycle();
      @(negedge clk);
      chk("t5_valid", 32'(instValid), 32'd1);
      chk("t5_pc", instPc, 32'h6);
      chk("t5_data", instData, memData(32'h4));
      chk("t5_misaligned", 32'(instMisaligned), 32'd0);
      nextCycle();
      instReady = 1'b1;
      nextCycle();
      instReady = 1'b0;
`endif

      // Spurious response with nothing outstanding.
      doReset();
      injectRsp = 1'b1;
      nextCycle();
      nextCycle();
      @(negedge clk);
      chk("t6_instValid", 32'(instValid), 32'd0);
      chk("t6_reserved", 32'(dut.reserved), 32'd0);
      chk("t6_dropCnt", 32'(dut.dropCnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction fetch stage between the program counter and decode in the single-cycle RISC-V core. It takes the current fetch PC and issues requests to a request/grant/response instruction memory. It tells the PC when to step and holds up to DEPTH fetched instructions, in order, each tagged with its PC. A redirect flush drops all queued and in-flight instructions.

## Interface
- DEPTH, 4, queue slots; power of two, ≥2
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- pc  in  32  current fetch PC from ProgramCounter
- pcAdvance  out  1  fetch accepted this cycle; PC steps next edge
- flush  in  1  redirect: discard queue and in-flight responses
- imemReq  out  1  fetch request
- imemAddr  out  32  fetch address, {pc[31:2],2'b00}
- imemGnt  in  1  memory accepts request this cycle
- imemRvalid  in  1  response valid; responses return in order, ≥1 cycle after grant
- imemRdata  in  32  response instruction
- instValid  out  1  head instruction valid to decode
- instData  out  32  head instruction
- instPc  out  32  head PC
- instReady  in  1  decode consumes head
- instMisaligned  out  1  head slot came from a misaligned PC

## Operation
- Slot queue: each slot holds {pc, data, filled, misaligned}. A slot is reserved at grant, with pc written and filled=0. It is filled by the next non-dropped response. Pop happens from the head only when filled.
- `reserved` = slots in use (0..DEPTH). `dropCnt` = responses still to discard (0..DEPTH). Counter width is $clog2(DEPTH)+1.
- imemReq = !reset & !flush & (reserved < DEPTH). Space for every response is guaranteed, so memory is never back-pressured.
- pcAdvance = imemReq & imemGnt.
- Response: if dropCnt>0, decrement dropCnt and discard the data. Otherwise fill the oldest unfilled slot. A response with no unfilled slot and dropCnt=0 is a protocol error and is ignored.
- Pop: instValid = head.filled. Pop on instValid & instReady.
- Flush has priority over everything in the same cycle:
  - queue emptied; reserved←0
  - dropCnt ← dropCnt + (number of reserved-but-unfilled slots) − (imemRvalid ? 1 : 0)
  - the pop that cycle is ignored
- Simultaneous grant, response and pop in one cycle are all applied. `reserved` changes by +grant −pop.

## Timing
- Reset values: instValid=0, pcAdvance=0, imemReq=0 while reset is high, instMisaligned=0, reserved=0, dropCnt=0, head/tail pointers 0. Reset mid-transfer behaves like a flush, except that in-flight responses after reset are not dropped; the memory is reset together with this block.
- imemReq and imemAddr are combinational from pc and state. They may change while pc changes.
- Latency from imemRvalid to instValid is 1 cycle (registered fill). A pop is effective at the next edge.
- In the cycle after a flush, imemReq may reassert with the redirected pc.
- Full: reserved=DEPTH → imemReq=0 until a pop.
- Pointers wrap modulo DEPTH.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - if pc[1:0]≠0 while a slot is free, no memory request is made (imemReq=0)
  - a slot is reserved and filled in the same cycle with data 32'h0000_0013 (NOP) and misaligned=1
  - pcAdvance=1 that cycle
  - instMisaligned reflects the head slot's misaligned bit
- Undefined: pc[1:0] is ignored and instMisaligned is tied 0.

## Structure
- Package fetch_pkg:
  - NOP_INST = 32'h0000_0013
  - fetch_slot_t struct {pc, data, filled, misaligned}
- Sub-module fetch_slot_queue (DEPTH): slot storage plus head/fill/tail pointers with reserve/fill/pop/clear controls. fetch_buffer holds the request logic, dropCnt and the flush rules.

## Test plan
- Reset, pc=0x0, imemGnt=1, response 1 cycle after each grant, instReady=1 → instructions arrive at PCs 0x0,0x4,0x8 in order. instValid first rises 2 cycles after the first grant.
- instReady=0, continuous grants → exactly 4 grants, then imemReq=0. Raising instReady for 1 cycle → one pop and one new grant.
- 3 requests granted, responses outstanding, flush → reserved=0 and dropCnt=3. The next 3 responses are discarded. The fetch from the redirected pc 0x100 is the first to reach decode.
- flush in the same cycle as imemRvalid and a valid pop → dropCnt counts that response, the pop is ignored, instValid=0 the next cycle.
- With FETCH_MISALIGN_CHECK_EN, pc=0x6 → imemReq=0, pcAdvance=1, head next cycle has instData=0x00000013, instPc=0x6, instMisaligned=1. Without the macro: imemAddr=0x4 and instMisaligned=0.
- Response with no outstanding request and dropCnt=0 → no state change, instValid stays 0.
